// File: rtl/apbtoahb_pkg.sv
// Shared encodings for the APB-to-AHB bridge: FSM states and fixed AHB control values.
`timescale 1ns/1ps
package apbtoahb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

endpackage

// File: rtl/apbtoahb_wdog.sv
// Wait-state watchdog: counts consecutive HREADY-low cycles of an AHB transfer and
// flags expiry on the cycle the count reaches TIMEOUT_CYCLES.
`timescale 1ns/1ps
module apbtoahb_wdog
    import apbtoahb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic HCLK,
    input  logic HRESETN,
    input  logic enable,
    input  logic hready,
    input  logic clear,
    output logic expired
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            count <= '0;
        end else if (clear || !enable || hready) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

    // Combinational so the FSM leaves on the same edge the count reaches the limit.
    assign expired = enable && !hready && (count == LAST_WAIT);

endmodule

// File: rtl/apb_to_ahb_bridge.sv
// APB3 completer that turns each APB access into one single-beat AHB-Lite transfer.
// Optional wait-state timeout is enabled with macro APBTOAHB_TIMEOUT_EN.
`timescale 1ns/1ps
module apb_to_ahb_bridge
    import apbtoahb_pkg::*;
#(
    parameter int TPD            = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    state_t      state;
    logic [31:0] haddr_q;
    logic [1:0]  htrans_q;
    logic        hwrite_q;
    logic [31:0] hwdata_q;
    logic [31:0] wdata_q;
    logic [31:0] prdata_q;
    logic        pready_q;
    logic        pslverr_q;
    logic        err_q;
    logic        timeout;

`ifdef APBTOAHB_TIMEOUT_EN
    apbtoahb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .enable  ((state == ADDR) || (state == DATA)),
        .hready  (HREADY),
        .clear   (state == IDLE),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETN) begin
        // NOTE: every register, including the write-data holding register, is reset so
        // the bus outputs are defined the instant HRESETN falls, even mid-transfer.
        if (!HRESETN) begin
            state     <= IDLE;
            haddr_q   <= '0;
            htrans_q  <= HTRANS_IDLE;
            hwrite_q  <= 1'b0;
            hwdata_q  <= '0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        haddr_q  <= PADDR;
                        hwrite_q <= PWRITE;
                        wdata_q  <= PWDATA;
                        err_q    <= 1'b0;
                        htrans_q <= HTRANS_NONSEQ;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (HREADY) begin
                        htrans_q <= HTRANS_IDLE;
                        hwdata_q <= wdata_q;
                        state    <= DATA;
                    end else if (timeout) begin
                        htrans_q  <= HTRANS_IDLE;
                        err_q     <= 1'b1;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        state     <= DONE;
                    end
                end
                DATA: begin
                    // The first cycle of a two-cycle ERROR response arrives with HREADY low.
                    if (HRESP) begin
                        err_q <= 1'b1;
                    end
                    if (HREADY) begin
                        if (!HRESP && !hwrite_q) begin
                            prdata_q <= HRDATA;
                        end
                        pready_q  <= 1'b1;
                        pslverr_q <= err_q || HRESP;
                        state     <= DONE;
                    end else if (timeout) begin
                        err_q     <= 1'b1;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign #TPD PRDATA    = prdata_q;
    assign #TPD PREADY    = pready_q;
    assign #TPD PSLVERR   = pslverr_q;
    assign #TPD HADDR     = haddr_q;
    assign #TPD HTRANS    = htrans_q;
    assign #TPD HWRITE    = hwrite_q;
    assign #TPD HWDATA    = hwdata_q;
    assign #TPD HSIZE     = HSIZE_WORD;
    assign #TPD HBURST    = HBURST_SINGLE;
    assign #TPD HMASTLOCK = 1'b0;
    assign #TPD HPROT     = HPROT_DEFAULT;

endmodule

// File: tb/tb_apb_to_ahb_bridge.sv
// Scoreboard bench for apb_to_ahb_bridge: APB driver, reactive AHB slave, APB monitor.
// Build with APBTOAHB_TIMEOUT_EN to exercise the wait-state timeout.
`timescale 1ns/1ps
module tb_apb_to_ahb_bridge;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam int         TO_CYC   = 16;

    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    apb_to_ahb_bridge #(
        .TPD            (1),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .HCLK      (HCLK),
        .HRESETN   (HRESETN),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HMASTLOCK (HMASTLOCK),
        .HPROT     (HPROT),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          aw;
        int          dw;
        logic [31:0] rdata;
        logic        err;
        bit          stuck;
    } ahb_exp_t;

    typedef struct {
        logic        err;
        logic [31:0] prdata;
    } apb_exp_t;

    ahb_exp_t ahb_q[$];
    apb_exp_t sb_q[$];
    int       ns_start_cyc[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ns_cycles = 0;
    int ns_exp    = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        if (HRESETN && HTRANS == T_NONSEQ) ns_cycles <= ns_cycles + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // APB monitor: every PREADY pulse retires the oldest expected completion.
    initial begin
        apb_exp_t e;
        forever begin
            @(negedge HCLK);
            if (HRESETN === 1'b1 && PREADY === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pready", 32'(PREADY), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("pslverr", 32'(PSLVERR), 32'(e.err));
                    check("prdata", PRDATA, e.prdata);
                end
            end
        end
    end

    // Reactive AHB slave: responds to each NONSEQ with the timing of the queued entry.
    initial begin
        ahb_exp_t t;
        int n;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        forever begin
            @(negedge HCLK);
            if (HRESETN === 1'b1 && HTRANS === T_NONSEQ) begin
                if (ahb_q.size() == 0) begin
                    check("unexpected_nonseq", 32'(HTRANS), 32'(T_IDLE));
                end else begin
                    t = ahb_q.pop_front();
                    ns_start_cyc.push_back(cyc);
                    check("haddr", HADDR, t.addr);
                    check("hwrite", 32'(HWRITE), 32'(t.wr));
                    check("hctrl", 32'({HSIZE, HBURST, HPROT, HMASTLOCK}),
                          32'({3'b010, 3'b000, 4'b0011, 1'b0}));
                    n = 0;
                    if (t.stuck) begin
                        while (HTRANS === T_NONSEQ && n < 1100) begin
                            HREADY = 1'b0;
                            n++;
                            @(negedge HCLK);
                        end
                        HREADY = 1'b1;
`ifdef APBTOAHB_TIMEOUT_EN
                        check("timeout_nonseq_cycles", 32'(n), 32'(TO_CYC));
`endif
                    end else begin
                        for (int i = 0; i < t.aw; i++) begin
                            HREADY = 1'b0;
                            @(negedge HCLK);
                            if (HTRANS === T_NONSEQ) n++;
                        end
                        check("nonseq_wait_cycles", 32'(n), 32'(t.aw));
                        HREADY = 1'b1;
                        @(negedge HCLK);
                        check("htrans_data_phase", 32'(HTRANS), 32'(T_IDLE));
                        if (t.wr) check("hwdata", HWDATA, t.wdata);
                        for (int i = 0; i < t.dw; i++) begin
                            HREADY = 1'b0;
                            HRESP  = t.err && (i == t.dw - 1);
                            @(negedge HCLK);
                        end
                        HREADY = 1'b1;
                        HRESP  = t.err;
                        HRDATA = t.rdata;
                        @(negedge HCLK);
                        HRESP  = 1'b0;
                        HRDATA = 32'hFFFF_FFFF;
                    end
                end
            end
        end
    end

    // One APB access; returns in the PREADY cycle with PSEL still asserted.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int aw, input int dw, input logic [31:0] rdata,
                            input logic err, input logic [31:0] exp_prdata,
                            input int exp_lat, input bit stuck);
        int idx;
        ahb_q.push_back('{addr, wr, wdata, aw, dw, rdata, err, stuck});
        sb_q.push_back('{err, exp_prdata});
        ns_exp += aw + 1;
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        idx = 1;
        @(negedge HCLK);
        PENABLE = 1'b1;
        idx = 2;
        while (PREADY !== 1'b1 && idx < 300) begin
            @(negedge HCLK);
            idx++;
        end
        check("pready_cycle", 32'(idx), 32'(exp_lat));
    endtask

    task automatic apb_idle();
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int b2b_idx;
        int pcount;
        HRESETN = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        repeat (3) @(negedge HCLK);
        check("rst_htrans", 32'(HTRANS), 32'(T_IDLE));
        check("rst_haddr", HADDR, 32'd0);
        check("rst_hwrite", 32'(HWRITE), 32'd0);
        check("rst_hwdata", HWDATA, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_pready", 32'(PREADY), 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_hctrl", 32'({HSIZE, HBURST, HPROT, HMASTLOCK}),
              32'({3'b010, 3'b000, 4'b0011, 1'b0}));
        HRESETN = 1'b1;
        repeat (2) @(negedge HCLK);
        check("idle_htrans", 32'(HTRANS), 32'(T_IDLE));

        // Zero-wait write, then read with three data wait states.
        apb_xfer(1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0, 32'h0, 4, 1'b0);
        apb_idle();
        apb_xfer(1'b0, 32'h2000_0010, 32'h0, 0, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 7, 1'b0);
        apb_idle();
        // Two-cycle ERROR on a read leaves PRDATA untouched.
        apb_xfer(1'b0, 32'h2000_0020, 32'h0, 0, 1, 32'hBAD0_BAD0, 1'b1, 32'h1234_5678, 5, 1'b0);
        apb_idle();

        // Back-to-back write then read; writes do not clear PRDATA.
        b2b_idx = ns_start_cyc.size();
        apb_xfer(1'b1, 32'h2000_0030, 32'hA5A5_5A5A, 0, 0, 32'h0, 1'b0, 32'h1234_5678, 4, 1'b0);
        apb_xfer(1'b0, 32'h2000_0034, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 4, 1'b0);
        apb_idle();
        check("b2b_nonseq_spacing", 32'(ns_start_cyc[b2b_idx + 1] - ns_start_cyc[b2b_idx]), 32'd4);

        // Address-phase waits with an unaligned address passed through.
        apb_xfer(1'b1, 32'h2000_0043, 32'h0BAD_F00D, 2, 1, 32'h0, 1'b0, 32'hCAFE_F00D, 7, 1'b0);
        apb_idle();

        // Reset pulsed during the data phase of a read.
        ahb_q.push_back('{32'h2000_0048, 1'b0, 32'h0, 0, 3, 32'hFFFF_0000, 1'b0, 1'b0});
        ns_exp += 1;
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h2000_0048;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        #1 HRESETN = 1'b0;
        #2;
        check("midrst_htrans", 32'(HTRANS), 32'(T_IDLE));
        check("midrst_pready", 32'(PREADY), 32'd0);
        check("midrst_haddr", HADDR, 32'd0);
        check("midrst_prdata", PRDATA, 32'd0);
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        HRESETN = 1'b1;
        repeat (6) @(negedge HCLK);

        apb_xfer(1'b1, 32'h2000_0050, 32'h5555_AAAA, 0, 0, 32'h0, 1'b0, 32'h0, 4, 1'b0);
        apb_idle();
        apb_xfer(1'b0, 32'h2000_0054, 32'h0, 0, 0, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 4, 1'b0);
        apb_idle();
        repeat (2) @(negedge HCLK);
        check("total_nonseq_cycles", 32'(ns_cycles), 32'(ns_exp));
        check("total_nonseq_starts", 32'(ns_start_cyc.size()), 32'd9);

        // HREADY stuck low.
`ifdef APBTOAHB_TIMEOUT_EN
        apb_xfer(1'b0, 32'h2000_0060, 32'h0, 0, 0, 32'h0, 1'b1, 32'h1357_9BDF, 2 + TO_CYC, 1'b1);
        apb_idle();
        repeat (2) @(negedge HCLK);
        check("post_timeout_htrans", 32'(HTRANS), 32'(T_IDLE));
`else
        ahb_q.push_back('{32'h2000_0060, 1'b0, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1});
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h2000_0060;
        @(negedge HCLK);
        PENABLE = 1'b1;
        pcount = 0;
        repeat (1000) begin
            @(negedge HCLK);
            if (PREADY === 1'b1) pcount++;
        end
        check("stuck_pready_count", 32'(pcount), 32'd0);
        check("stuck_htrans", 32'(HTRANS), 32'(T_NONSEQ));
        HRESETN = 1'b0;
        #2;
        check("stuck_rst_htrans", 32'(HTRANS), 32'(T_IDLE));
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        HRESETN = 1'b1;
        repeat (3) @(negedge HCLK);
`endif

        check("sb_remaining", 32'(sb_q.size()), 32'd0);
        check("ahb_remaining", 32'(ahb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_to_ahb_bridge.md
# apb_to_ahb_bridge

- APB3 completer (slave) that converts each APB access into one single-beat AHB-Lite transfer, acting as the AHB-Lite manager (master).
- Sits in the AMBA BFM set as the counterpart of the AHB-to-APB bridge: it lets an APB-side BFM or peripheral reach AHB-attached memories and registers.
- PREADY is held low until the AHB data phase completes. HRESP maps to PSLVERR.

## Interface
- TPD, 1: delay applied to every output assign, in ns.
- TIMEOUT_CYCLES, 255: limit on consecutive HREADY-low cycles (8-bit; used only with the timeout feature).
- HCLK  in  1  clock; all logic on the rising edge.
- HRESETN  in  1  reset; asynchronous, active-low.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable (access phase).
- PWRITE  in  1  APB direction.
- PADDR  in  32  APB address.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
- HADDR  out  32  AHB address.
- HTRANS  out  2  transfer type (IDLE=00, NONSEQ=10).
- HWRITE  out  1  AHB direction.
- HSIZE  out  3  fixed 3'b010 (word).
- HBURST  out  3  fixed 3'b000 (SINGLE).
- HMASTLOCK  out  1  fixed 0.
- HPROT  out  4  fixed 4'b0011.
- HWDATA  out  32  AHB write data.
- HRDATA  in  32  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  1  AHB error response.

## Operation
- Values on reset, and while HRESETN is low:
  - state IDLE
  - HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0
  - PRDATA=0, PREADY=0, PSLVERR=0
  - error flag cleared; timeout counter 0.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE
  - On PSEL=1 & PENABLE=0 (setup phase): capture PADDR into HADDR, PWRITE into HWRITE, PWDATA into a write-data register; clear the error flag; go to ADDR.
  - Otherwise remain in IDLE.
- ADDR
  - HTRANS=NONSEQ.
  - On HREADY=1: HTRANS becomes IDLE, HWDATA is driven from the write-data register, go to DATA.
  - On HREADY=0: hold address and control unchanged.
- DATA
  - HREADY=1 & HRESP=0: if a read, capture HRDATA into PRDATA; go to DONE.
  - HRESP=1 (either error cycle): set the error flag.
  - HREADY=1 & HRESP=1: go to DONE with the error flag set.
  - HREADY=0: remain in DATA.
- DONE
  - PREADY=1; PSLVERR=error flag.
  - Go to IDLE next cycle. PREADY and PSLVERR return to 0.
- PREADY is 1 only in DONE. The APB requester must hold PSEL/PENABLE/PADDR stable until then.
- PRDATA is held until the next read completes and is not cleared by writes. On a read error, PRDATA is not updated.
- PADDR[1:0] is passed through unchanged. Address alignment is the requester's responsibility.

## Timing
- All outputs are registered, then delayed by #TPD.
- Zero-wait AHB:
  - T0: APB setup phase.
  - T1: ADDR, HTRANS=NONSEQ.
  - T2: DATA.
  - T3: DONE, PREADY=1.
  - The APB access completes at the end of T3 (4-cycle APB transfer).
- Each AHB wait state (HREADY=0) in ADDR or DATA adds one cycle.
- HTRANS=NONSEQ is presented for exactly the cycles spent in ADDR; never two NONSEQs for one APB access.
- Back-to-back: a new setup phase in the cycle after DONE is accepted. Minimum 4 cycles per access.
- PSEL dropped mid-transfer (protocol violation):
  - the AHB transfer still completes;
  - the FSM passes through DONE to IDLE;
  - there is no abort on AHB.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronous); HTRANS=IDLE without completing the beat.

## Configuration
- Macro APBTOAHB_TIMEOUT_EN.
- Defined:
  - an 8-bit counter increments on every HREADY=0 cycle in ADDR or DATA and clears on HREADY=1 or in IDLE;
  - when the count reaches TIMEOUT_CYCLES, go to DONE with PSLVERR=1 and HTRANS=IDLE;
  - PRDATA is unchanged.
- Undefined: no counter is present and the bridge waits on HREADY indefinitely. TIMEOUT_CYCLES is ignored.

## Structure
- Package apbtoahb_pkg holds:
  - state encodings (IDLE=0, ADDR=1, DATA=2, DONE=3);
  - HTRANS_IDLE / HTRANS_NONSEQ;
  - HSIZE_WORD, HBURST_SINGLE, HPROT_DEFAULT.
- One sub-module, apbtoahb_wdog: the timeout counter. It is instantiated only under APBTOAHB_TIMEOUT_EN, with inputs enable, hready and clear and output expired.

## Test plan
- Write PADDR=0x2000_0010, PWDATA=0xDEAD_BEEF, zero-wait AHB -> one NONSEQ at 0x2000_0010 with HWRITE=1; HWDATA=0xDEAD_BEEF in the next cycle; PREADY=1, PSLVERR=0 at T3.
- Read 0x2000_0010, slave returns 0x1234_5678 after 3 wait states -> PRDATA=0x1234_5678; PREADY first high 7 cycles after setup.
- Two-cycle AHB ERROR on a read -> PSLVERR=1 with PREADY; PRDATA keeps its previous value.
- Back-to-back write then read -> two NONSEQs, 4 cycles apart; no extra HTRANS activity between them.
- HRESETN pulsed low during DATA -> HTRANS=00 and PREADY=0 immediately; next setup phase is accepted normally.
- With APBTOAHB_TIMEOUT_EN and TIMEOUT_CYCLES=16, HREADY stuck low -> PREADY=1 with PSLVERR=1 after 16 wait cycles. Without the macro, PREADY stays 0 for 1000 cycles.
